// File: rtl/phy_rx_frame_assembler.sv
// Receive-side nibble-to-byte assembler: strips preamble/SFD, rebuilds bytes and
// closes each frame with a length and error status.
module phy_rx_frame_assembler #(
    parameter int MIN_LEN          = 64,
    parameter int MAX_LEN          = 1518,
    parameter int MAX_PREAMBLE     = 15,
    parameter int REQUIRE_PREAMBLE = 1
) (
    input  logic        clk_phy,
    input  logic        reset_n,
    input  logic [3:0]  phy_data_in,
    input  logic        phy_tx_en,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        frame_start,
    output logic        frame_end,
    output logic [11:0] frame_len,
    output logic        frame_err,
    output logic [2:0]  err_code,
    output logic [15:0] frame_count
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [11:0] MIN_L   = 12'(MIN_LEN);
    localparam logic [11:0] MAX_L   = 12'(MAX_LEN);
    localparam logic [7:0]  PRE_MAX = 8'(MAX_PREAMBLE);

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_PRE   = 3'd1;
    localparam logic [2:0] ERR_ODD   = 3'd2;
    localparam logic [2:0] ERR_RUNT  = 3'd3;
    localparam logic [2:0] ERR_OVER  = 3'd4;
    localparam logic [2:0] ERR_CARR  = 3'd5;

    state_t      state;
    logic [7:0]  pre_cnt;
    logic        phase;
    logic [3:0]  low;
    logic [11:0] len;
    logic [2:0]  code;

    always_ff @(posedge clk_phy or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pre_cnt     <= '0;
            phase       <= 1'b0;
            low         <= '0;
            len         <= '0;
            code        <= ERR_NONE;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_len   <= '0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
            frame_count <= '0;
        end else begin
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            case (state)
                IDLE: begin
                    if (phy_tx_en) begin
                        len   <= '0;
                        phase <= 1'b0;
                        if (phy_data_in == 4'h5) begin
                            state   <= PREAMBLE;
                            pre_cnt <= 8'd1;
                        end else if (REQUIRE_PREAMBLE != 0) begin
                            state <= DROP;
                            code  <= ERR_PRE;
                        end else begin
                            // No preamble expected: this nibble is already the low half of byte 0.
                            state <= DATA;
                            low   <= phy_data_in;
                            phase <= 1'b1;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!phy_tx_en) begin
                        state     <= IDLE;
                        frame_end <= 1'b1;
                        frame_err <= 1'b1;
                        err_code  <= ERR_CARR;
                        frame_len <= '0;
                    end else if (phy_data_in == 4'h5) begin
                        if (pre_cnt == PRE_MAX) begin
                            state <= DROP;
                            code  <= ERR_PRE;
                        end else begin
                            pre_cnt <= pre_cnt + 8'd1;
                        end
                    end else if (phy_data_in == 4'hD) begin
                        state <= DATA;
                        phase <= 1'b0;
                        len   <= '0;
                    end else begin
                        state <= DROP;
                        code  <= ERR_PRE;
                    end
                end
                DATA: begin
                    if (!phy_tx_en) begin
                        state     <= IDLE;
                        phase     <= 1'b0;
                        frame_end <= 1'b1;
                        frame_len <= len;
                        if (phase) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_ODD;
                        end else if (len < MIN_L) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_RUNT;
                        end else begin
                            frame_err   <= 1'b0;
                            err_code    <= ERR_NONE;
                            frame_count <= frame_count + 16'd1;
                        end
                    end else if (!phase) begin
                        low   <= phy_data_in;
                        phase <= 1'b1;
                    end else if (len == MAX_L) begin
                        // The byte past MAX_LEN is swallowed, so len stays capped.
                        state <= DROP;
                        code  <= ERR_OVER;
                    end else begin
                        byte_out    <= {phy_data_in, low};
                        byte_valid  <= 1'b1;
                        frame_start <= (len == 12'd0);
                        len         <= len + 12'd1;
                        phase       <= 1'b0;
                    end
                end
                DROP: begin
                    if (!phy_tx_en) begin
                        state     <= IDLE;
                        frame_end <= 1'b1;
                        frame_err <= 1'b1;
                        err_code  <= code;
                        frame_len <= len;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phy_rx_frame_assembler.sv
// Directed bench for phy_rx_frame_assembler: a table of frame shapes with
// hand-computed outcomes, plus back-to-back and mid-frame reset sequences.
module tb_phy_rx_frame_assembler;

    logic        clk_phy = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  phy_data_in = '0;
    logic        phy_tx_en = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_valid, frame_start, frame_end, frame_err;
    logic [11:0] frame_len;
    logic [2:0]  err_code;
    logic [15:0] frame_count;

    phy_rx_frame_assembler #(.MIN_LEN(64), .MAX_LEN(1518), .MAX_PREAMBLE(15), .REQUIRE_PREAMBLE(1)) dut (
        .clk_phy(clk_phy), .reset_n(reset_n), .phy_data_in(phy_data_in), .phy_tx_en(phy_tx_en),
        .byte_out(byte_out), .byte_valid(byte_valid), .frame_start(frame_start), .frame_end(frame_end),
        .frame_len(frame_len), .frame_err(frame_err), .err_code(err_code), .frame_count(frame_count)
    );

    always #5 clk_phy = ~clk_phy;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int k);
        return 8'(k * 13 + 5);
    endfunction

    // Output monitor, sampled on the falling edge
    int tot_bytes = 0, tot_starts = 0, tot_fe = 0, tot_good = 0, bad_bytes = 0, overlap = 0, idx = 0;
    int last_err = 0, last_code = 0, last_len = 0, last_cnt = 0;
    always @(negedge clk_phy) begin
        if (byte_valid) begin
            if (frame_start) begin
                tot_starts++;
                idx = 0;
            end
            if (byte_out != pat(idx)) bad_bytes++;
            idx++;
            tot_bytes++;
        end
        if (frame_end) begin
            tot_fe++;
            if (!frame_err) tot_good++;
            last_err  = frame_err;
            last_code = err_code;
            last_len  = frame_len;
            last_cnt  = frame_count;
        end
        if (byte_valid && frame_end) overlap++;
    end

    task automatic drive(input logic en, input logic [3:0] d);
        @(negedge clk_phy);
        phy_tx_en   = en;
        phy_data_in = d;
    endtask

    task automatic send(input int pre, input logic [3:0] sfd, input bit use_sfd, input int nb, input bit odd);
        logic [7:0] b;
        for (int i = 0; i < pre; i++) drive(1'b1, 4'h5);
        if (use_sfd) drive(1'b1, sfd);
        for (int i = 0; i < nb; i++) begin
            b = pat(i);
            drive(1'b1, b[3:0]);
            drive(1'b1, b[7:4]);
        end
        if (odd) drive(1'b1, 4'h9);
        drive(1'b0, 4'h0);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk_phy);
        #1;
    endtask

    typedef struct {
        int         pre;
        logic [3:0] sfd;
        bit         use_sfd;
        int         nbytes;
        bit         odd;
        int         exp_bytes;
        int         exp_err;
        int         exp_code;
        int         exp_len;
        int         exp_good;
    } vec_t;

    vec_t vecs[11];
    int   exp_count = 0;

    initial begin
        int b0, s0, f0, g0, bb0;
        vecs[0]  = '{7,  4'hD, 1'b1, 512,  1'b0, 512,  0, 0, 512,  1};
        vecs[1]  = '{7,  4'hD, 1'b1, 512,  1'b1, 512,  1, 2, 512,  0};
        vecs[2]  = '{7,  4'hD, 1'b1, 40,   1'b0, 40,   1, 3, 40,   0};
        vecs[3]  = '{7,  4'hD, 1'b1, 1600, 1'b0, 1518, 1, 4, 1518, 0};
        vecs[4]  = '{2,  4'h3, 1'b1, 4,    1'b0, 0,    1, 1, 0,    0};
        vecs[5]  = '{16, 4'hD, 1'b1, 4,    1'b0, 0,    1, 1, 0,    0};
        vecs[6]  = '{3,  4'hD, 1'b0, 0,    1'b0, 0,    1, 5, 0,    0};
        vecs[7]  = '{15, 4'hD, 1'b1, 64,   1'b0, 64,   0, 0, 64,   1};
        vecs[8]  = '{1,  4'hD, 1'b1, 63,   1'b0, 63,   1, 3, 63,   0};
        vecs[9]  = '{7,  4'hD, 1'b1, 1518, 1'b0, 1518, 0, 0, 1518, 1};
        vecs[10] = '{0,  4'hD, 1'b1, 4,    1'b0, 0,    1, 1, 0,    0};

        repeat (3) @(negedge clk_phy);
        #1;
        chk("reset byte_valid", int'(byte_valid), 0);
        chk("reset frame_end", int'(frame_end), 0);
        chk("reset frame_len", int'(frame_len), 0);
        chk("reset err", int'({frame_err, err_code}), 0);
        chk("reset frame_count", int'(frame_count), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_phy);

        for (int v = 0; v < 11; v++) begin
            b0 = tot_bytes; s0 = tot_starts; f0 = tot_fe; bb0 = bad_bytes;
            send(vecs[v].pre, vecs[v].sfd, vecs[v].use_sfd, vecs[v].nbytes, vecs[v].odd);
            settle();
            exp_count += vecs[v].exp_good;
            $display("vector %0d", v);
            chk("byte strobes", tot_bytes - b0, vecs[v].exp_bytes);
            chk("frame_start count", tot_starts - s0, (vecs[v].exp_bytes > 0) ? 1 : 0);
            chk("byte data errors", bad_bytes - bb0, 0);
            chk("frame_end count", tot_fe - f0, 1);
            chk("frame_err", last_err, vecs[v].exp_err);
            chk("err_code", last_code, vecs[v].exp_code);
            chk("frame_len at end", last_len, vecs[v].exp_len);
            chk("frame_len held", int'(frame_len), vecs[v].exp_len);
            chk("frame_count at end", last_cnt, exp_count);
        end

        // 64 good frames separated by a single low tx_en cycle
        b0 = tot_bytes; f0 = tot_fe; g0 = tot_good; bb0 = bad_bytes;
        for (int n = 0; n < 64; n++) send(7, 4'hD, 1'b1, 64, 1'b0);
        settle();
        exp_count += 64;
        chk("b2b frame_end", tot_fe - f0, 64);
        chk("b2b good", tot_good - g0, 64);
        chk("b2b bytes", tot_bytes - b0, 64 * 64);
        chk("b2b data errors", bad_bytes - bb0, 0);
        chk("b2b frame_count", int'(frame_count), exp_count);

        // Reset in the middle of a frame, then a clean frame
        f0 = tot_fe;
        begin
            logic [7:0] b;
            for (int i = 0; i < 7; i++) drive(1'b1, 4'h5);
            drive(1'b1, 4'hD);
            for (int i = 0; i < 200; i++) begin
                b = pat(i);
                drive(1'b1, b[3:0]);
                drive(1'b1, b[7:4]);
            end
        end
        @(negedge clk_phy);
        reset_n   = 1'b0;
        phy_tx_en = 1'b0;
        #1;
        chk("mid reset byte_valid", int'(byte_valid), 0);
        chk("mid reset frame_count", int'(frame_count), 0);
        chk("mid reset frame_len", int'(frame_len), 0);
        @(negedge clk_phy);
        reset_n = 1'b1;
        settle();
        chk("no frame_end after reset", tot_fe - f0, 0);
        b0 = tot_bytes;
        send(7, 4'hD, 1'b1, 512, 1'b0);
        settle();
        chk("post-reset bytes", tot_bytes - b0, 512);
        chk("post-reset frame_end", tot_fe - f0, 1);
        chk("post-reset frame_err", last_err, 0);
        chk("post-reset frame_len", last_len, 512);
        chk("post-reset frame_count", int'(frame_count), 1);
        chk("byte_valid with frame_end", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phy_rx_frame_assembler.md
Name: phy_rx_frame_assembler

Overview:
Downstream PHY-side stage of the transmit path. Consumes the 4-bit nibble stream and tx-enable driven out of the xmit top level (phy_data_out / phy_tx_en), strips preamble/SFD, reassembles bytes, and reports per-frame length and error status. Used as a loopback checker and as the receive front end feeding frame statistics; all logic sits in the clk_phy domain.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (after SFD)
MAX_LEN, 1518, maximum legal frame length in bytes; must be < 4096
MAX_PREAMBLE, 15, maximum 0x5 preamble nibbles tolerated before SFD
REQUIRE_PREAMBLE, 1, 1: preamble+SFD mandatory; 0: first nibble under tx_en is data

Ports:
clk_phy  in  1  PHY clock; all state on rising edge
reset_n  in  1  asynchronous, active-low reset
phy_data_in  in  4  nibble from xmit stage, low nibble of each byte first
phy_tx_en  in  1  nibble valid / carrier
byte_out  out  8  reassembled byte
byte_valid  out  1  one-cycle strobe, byte_out valid
frame_start  out  1  high with byte_valid on first byte of a frame
frame_end  out  1  one-cycle strobe, frame closed (good or bad)
frame_len  out  12  byte count of closed frame, valid with frame_end, held until next frame_end
frame_err  out  1  valid with frame_end; 1 = frame bad
err_code  out  3  valid with frame_end: 0 none, 1 bad preamble/SFD, 2 odd nibble count, 3 runt, 4 oversize, 5 carrier lost before SFD
frame_count  out  16  count of good frames, wraps 0xFFFF->0

Behaviour:
- Reset (reset_n low, async): state IDLE; all outputs 0; nibble phase 0; internal length 0; frame_count 0. Reset mid-frame discards the frame with no frame_end.
- Inputs sampled on each rising clk_phy; no input synchroniser (same domain).
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE: tx_en=1 & nibble=0x5 -> PREAMBLE (pre_cnt=1). tx_en=1 & other nibble -> DROP, code 1 (REQUIRE_PREAMBLE=1) or DATA with that nibble as low nibble, phase 1 (REQUIRE_PREAMBLE=0).
- PREAMBLE: nibble 0x5 -> stay, pre_cnt+1; pre_cnt reaching MAX_PREAMBLE+1 -> DROP code 1. nibble 0xD -> DATA, phase 0, len 0. other nibble -> DROP code 1. tx_en=0 -> IDLE, frame_end with frame_err=1, code 5, frame_len 0.
- DATA: phase 0 latch low nibble; phase 1 form byte {nibble, low}. byte_out/byte_valid registered: strobe in the cycle after the high nibble is sampled (latency 1 clk_phy). frame_start=1 on the byte where len was 0. len increments per byte; byte that would make len = MAX_LEN+1 is not emitted -> DROP code 4.
- DATA, tx_en=0 sampled: frame_end next cycle with frame_len=len. Priority: phase 1 (odd nibble) -> code 2; else len<MIN_LEN -> code 3; else good, frame_err=0, frame_count+1 in same cycle as frame_end. Dangling low nibble discarded.
- DROP: ignore nibbles, no byte_valid, len frozen; on tx_en=0 -> frame_end with frame_err=1 and recorded code, -> IDLE.
- Last byte's byte_valid and frame_end are never in the same cycle; frame_end follows by >=1 cycle.
- Back-to-back: one tx_en=0 cycle suffices; tx_en=1 in the cycle after the closing low cycle is processed from IDLE normally, while frame_end of the prior frame is being driven.
- frame_len saturating impossible: oversize caps len at MAX_LEN.

Test Plan:
- Preamble 7x0x5, SFD 0xD, 512 bytes 0x00x4/0xFFx504/0x00x4 -> 512 byte_valid strobes, frame_start on first 0x00, frame_end with frame_len=0x200, frame_err=0, frame_count=1.
- 64 back-to-back 512-byte frames with 1-cycle tx_en gap -> 64 good frame_end, frame_count=64, no bytes lost.
- Good preamble, 1025 nibbles then tx_en low -> frame_end, err_code=2, frame_len=512, frame_count unchanged.
- 40-byte frame -> err_code=3, frame_len=40; 1600-byte frame (MAX_LEN=1518) -> exactly 1518 byte_valid, err_code=4, frame_len=1518.
- Preamble 0x5,0x5,0x3 -> err_code=1 with no byte_valid; 16x0x5 with MAX_PREAMBLE=15 -> err_code=1; 0x5x3 then tx_en low -> err_code=5.
- reset_n low for 1 cycle at byte 200 of a frame -> outputs 0 immediately, no frame_end; next clean frame reported good with frame_count=1.
